// File: rtl/io_mem_periph.sv
// ============================================================================
// Module   : io_mem_periph
// Purpose  : CPU bus slave with a word RAM, a TX FIFO feeding an 8N1 UART,
//            a GPIO register and a free-running cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module io_mem_periph #(
    parameter int RAM_AW       = 10,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] i_ioaddr,
    input  logic [31:0] i_iodat,
    input  logic        i_memread,
    input  logic        i_memwrite,
    output logic [31:0] o_iodat,
    output logic        o_uart_tx,
    output logic [31:0] o_gpio
);

    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int BAUD_W     = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              periph_sel;
    logic              periph_mapped;
    logic [1:0]        reg_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_ram, wr_tx, wr_status, wr_gpio;
    logic              unused_addr_bits;

    assign periph_sel       = i_ioaddr[31];
    assign periph_mapped    = (i_ioaddr[30:4] == '0);
    assign reg_sel          = i_ioaddr[3:2];
    assign ram_idx          = i_ioaddr[RAM_AW+1:2];
    assign unused_addr_bits = ^i_ioaddr[1:0];

    assign wr_ram    = i_memwrite && !periph_sel;
    assign wr_tx     = i_memwrite && periph_sel && periph_mapped && (reg_sel == 2'd0);
    assign wr_status = i_memwrite && periph_sel && periph_mapped && (reg_sel == 2'd1);
    assign wr_gpio   = i_memwrite && periph_sel && periph_mapped && (reg_sel == 2'd2);

    // ------------------------------------------------------------------
    // Storage without reset
    // ------------------------------------------------------------------
    logic [31:0] ram_q [2**RAM_AW];
    logic [7:0]  fifo_mem_q [FIFO_DEPTH];

    always_ff @(posedge clock) begin
        if (wr_ram) begin
            ram_q[ram_idx] <= i_iodat;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    state_t             state_q, state_d;

    assign fifo_full  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_pop   = (state_q == S_IDLE) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    assign fifo_push  = wr_tx && (!fifo_full || fifo_pop);

    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= i_iodat[7:0];
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_tx && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end else if (wr_status && i_iodat[6]) begin
            overflow_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter FSM
    // ------------------------------------------------------------------
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              baud_done;

    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    shift_d = fifo_mem_q[rd_ptr_q];
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // GPIO and cycle counter
    // ------------------------------------------------------------------
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] cyc_q, cyc_d;

    assign gpio_d = wr_gpio ? i_iodat : gpio_q;
    assign cyc_d  = cyc_q + 32'd1;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            gpio_q     <= '0;
            cyc_q      <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            gpio_q     <= gpio_d;
            cyc_q      <= cyc_d;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read path
    // ------------------------------------------------------------------
    logic [31:0] status;
    logic [31:0] rdata;

    assign status = {25'd0, overflow_q, 3'(count_q), fifo_empty, fifo_full,
                     (state_q != S_IDLE)};

    always_comb begin
        rdata = '0;
        if (!periph_sel) begin
            rdata = ram_q[ram_idx];
        end else if (periph_mapped) begin
            case (reg_sel)
                2'd1:    rdata = status;
                2'd2:    rdata = gpio_q;
                2'd3:    rdata = cyc_q;
                default: rdata = '0;
            endcase
        end
    end

    assign o_iodat   = i_memread ? rdata : '0;
    assign o_uart_tx = tx_q;
    assign o_gpio    = gpio_q;

endmodule

`default_nettype wire

// File: tb/tb_io_mem_periph.sv
// ============================================================================
// Module   : tb_io_mem_periph
// Purpose  : Directed self-checking bench for io_mem_periph (CLKS_PER_BIT = 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_io_mem_periph;

    localparam int CPB = 4;

    localparam logic [31:0] A_TX     = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_GPIO   = 32'h8000_0008;
    localparam logic [31:0] A_CYC    = 32'h8000_000C;

    logic        clock;
    logic        rst;
    logic [31:0] i_ioaddr;
    logic [31:0] i_iodat;
    logic        i_memread;
    logic        i_memwrite;
    logic [31:0] o_iodat;
    logic        o_uart_tx;
    logic [31:0] o_gpio;

    int errors = 0;
    int checks = 0;

    io_mem_periph #(
        .RAM_AW      (10),
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (2)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .i_ioaddr  (i_ioaddr),
        .i_iodat   (i_iodat),
        .i_memread (i_memread),
        .i_memwrite(i_memwrite),
        .o_iodat   (o_iodat),
        .o_uart_tx (o_uart_tx),
        .o_gpio    (o_gpio)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        i_ioaddr   = a;
        i_iodat    = d;
        i_memwrite = 1'b1;
        @(posedge clock);
        #1;
        i_memwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        i_ioaddr  = a;
        i_memread = 1'b1;
        #1;
        d = o_iodat;
        i_memread = 1'b0;
    endtask

    // Samples one 8N1 frame mid-bit; ok = 0 on timeout or framing error.
    task automatic rx_byte(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < 400 && o_uart_tx !== 1'b0; i++) @(negedge clock);
        if (o_uart_tx !== 1'b0) return;
        repeat (2) @(negedge clock);
        if (o_uart_tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            b[i] = o_uart_tx;
        end
        repeat (CPB) @(negedge clock);
        ok = (o_uart_tx === 1'b1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; i_ioaddr = '0; i_iodat = '0; i_memread = 1'b0; i_memwrite = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (o_uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", o_uart_tx); end
        checks++; if (o_gpio !== 32'h0) begin errors++; $display("FAIL reset_gpio got %h exp 0", o_gpio); end
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status got %h exp 00000004", d); end
        bus_read(A_CYC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cycles got %h exp 0", d); end
        @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic test_cycles();
        logic [31:0] d;
        repeat (7) @(posedge clock);
        #1;
        bus_read(A_CYC, d);
        checks++; if (d !== 32'd7) begin errors++; $display("FAIL cycles_n7 got %0d exp 7", d); end
        repeat (3) @(posedge clock);
        #1;
        bus_read(A_CYC, d);
        checks++; if (d !== 32'd10) begin errors++; $display("FAIL cycles_n10 got %0d exp 10", d); end
    endtask

    task automatic test_cycles_wrap();
        logic [31:0] d;
        @(negedge clock);
        force dut.cyc_d = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut.cyc_d;
        bus_read(A_CYC, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycles_max got %h exp ffffffff", d); end
        @(negedge clock);
        bus_read(A_CYC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL cycles_wrap got %h exp 0", d); end
    endtask

    task automatic test_ram();
        logic [31:0] d;
        bus_write(32'h0000_0010, 32'hDEAD_BEEF);
        bus_read(32'h0000_0010, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd got %h exp deadbeef", d); end
        bus_read(32'h0000_1010, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias got %h exp deadbeef", d); end
        bus_read(32'h0000_0013, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_lowbits got %h exp deadbeef", d); end
        i_ioaddr = 32'h0000_0010; i_memread = 1'b0;
        #1;
        checks++; if (o_iodat !== 32'h0) begin errors++; $display("FAIL ram_noread got %h exp 0", o_iodat); end
        // Simultaneous read and write: read shows the old word.
        @(negedge clock);
        i_ioaddr = 32'h0000_0010; i_iodat = 32'h1234_5678; i_memread = 1'b1; i_memwrite = 1'b1;
        #1;
        checks++; if (o_iodat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rdwr_old got %h exp deadbeef", o_iodat); end
        @(posedge clock);
        #1;
        i_memwrite = 1'b0; i_memread = 1'b0;
        bus_read(32'h0000_0010, d);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_rdwr_new got %h exp 12345678", d); end
    endtask

    task automatic test_gpio_unmapped();
        logic [31:0] d, c0;
        bus_write(A_GPIO, 32'h0000_00A5);
        checks++; if (o_gpio !== 32'hA5) begin errors++; $display("FAIL gpio_out got %h exp 000000a5", o_gpio); end
        bus_read(A_GPIO, d);
        checks++; if (d !== 32'hA5) begin errors++; $display("FAIL gpio_rd got %h exp 000000a5", d); end
        bus_write(32'h8000_0010, 32'hFFFF_FFFF);
        checks++; if (o_gpio !== 32'hA5) begin errors++; $display("FAIL unmapped_wr got %h exp 000000a5", o_gpio); end
        bus_read(32'h8000_0010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %h exp 0", d); end
        bus_read(A_TX, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_rd got %h exp 0", d); end
        @(negedge clock);
        bus_read(A_CYC, c0);
        i_ioaddr = A_CYC; i_iodat = 32'h0; i_memwrite = 1'b1;
        @(posedge clock);
        #1;
        i_memwrite = 1'b0;
        bus_read(A_CYC, d);
        checks++; if (d !== c0 + 32'd1) begin errors++; $display("FAIL cycles_ro got %h exp %h", d, c0 + 32'd1); end
    endtask

    task automatic test_uart_frame();
        logic [7:0]  byte_v;
        logic [31:0] d;
        logic        exp_tx, exp_busy;
        byte_v = 8'h55;
        bus_write(A_TX, {24'h0, byte_v});
        // c counts negedges after the push edge; the frame occupies c = 2..41.
        for (int c = 0; c <= 44; c++) begin
            @(negedge clock);
            if (c >= 2 && c <= 5)        exp_tx = 1'b0;
            else if (c >= 6 && c <= 37)  exp_tx = byte_v[(c - 6) / CPB];
            else                         exp_tx = 1'b1;
            exp_busy = (c >= 1 && c <= 40);
            checks++; if (o_uart_tx !== exp_tx) begin errors++; $display("FAIL uart_tx c=%0d got %b exp %b", c, o_uart_tx, exp_tx); end
            bus_read(A_STATUS, d);
            checks++; if (d[0] !== exp_busy) begin errors++; $display("FAIL uart_busy c=%0d got %b exp %b", c, d[0], exp_busy); end
        end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0]  rx [5];
        bit          ok [5];
        logic [31:0] d;
        bit          extra;
        fork
            begin
                for (int i = 1; i <= 6; i++) bus_write(A_TX, i);
                bus_read(A_STATUS, d);
                checks++; if (d !== 32'h63) begin errors++; $display("FAIL fifo_full_status got %h exp 00000063", d); end
            end
            begin
                for (int i = 0; i < 5; i++) rx_byte(rx[i], ok[i]);
            end
        join
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!ok[i] || rx[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL fifo_rx%0d got %h ok=%0d exp %h", i, rx[i], ok[i], 8'(i + 1));
            end
        end
        extra = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (o_uart_tx !== 1'b1) extra = 1'b1;
        end
        checks++; if (extra) begin errors++; $display("FAIL fifo_dropped got extra_frame exp none"); end
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h44) begin errors++; $display("FAIL ovf_sticky got %h exp 00000044", d); end
        bus_write(A_STATUS, 32'h0000_0040);
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h04) begin errors++; $display("FAIL ovf_clear got %h exp 00000004", d); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        bus_write(A_GPIO, 32'h0000_5A5A);
        bus_write(A_TX, 32'h0000_0000);
        repeat (14) @(negedge clock);
        checks++; if (o_uart_tx !== 1'b0) begin errors++; $display("FAIL mid_pre_tx got %b exp 0", o_uart_tx); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (o_uart_tx !== 1'b1) begin errors++; $display("FAIL mid_rst_tx got %b exp 1", o_uart_tx); end
        checks++; if (o_gpio !== 32'h0) begin errors++; $display("FAIL mid_rst_gpio got %h exp 0", o_gpio); end
        bus_read(A_STATUS, d);
        checks++; if (d !== 32'h04) begin errors++; $display("FAIL mid_rst_status got %h exp 00000004", d); end
        @(negedge clock);
        rst = 1'b0;
        repeat (20) @(negedge clock);
        checks++; if (o_uart_tx !== 1'b1) begin errors++; $display("FAIL mid_post_idle got %b exp 1", o_uart_tx); end
    endtask

    initial begin
        test_reset();
        test_cycles();
        test_ram();
        test_gpio_unmapped();
        test_uart_frame();
        test_fifo_overflow();
        test_cycles_wrap();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
